// File: rtl/amber128_reset_seq_if.sv
// Signal bundle between the reset sequencer and its environment.
// The sequencer takes the slave side; the platform (or a bench) takes the master side.
interface amber128_reset_seq_if;
    logic       pll_locked_i;
    logic       sw_rst_req_i;
    logic       rst_periph_no;
    logic       rst_mem_no;
    logic       rst_core_no;
    logic       busy_o;
    logic       sw_ack_o;
    logic [1:0] cause_o;

    modport master (
        output pll_locked_i, sw_rst_req_i,
        input  rst_periph_no, rst_mem_no, rst_core_no, busy_o, sw_ack_o, cause_o
    );

    modport slave (
        input  pll_locked_i, sw_rst_req_i,
        output rst_periph_no, rst_mem_no, rst_core_no, busy_o, sw_ack_o, cause_o
    );
endinterface

// File: rtl/amber128_reset_seq.sv
// Staged reset sequencer: waits for PLL lock, holds all domains in reset,
// then releases peripherals, memory and core in that order. A loss of lock
// or an accepted software request re-asserts every domain. The cause of the
// most recent reset is kept for boot firmware.
module amber128_reset_seq #(
    parameter int HOLD_CYCLES      = 16,
    parameter int STEP_CYCLES      = 8,
    parameter int CNT_W            = 8,
    parameter int LOCK_SYNC_STAGES = 2
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    amber128_reset_seq_if.slave  bus
);

    // Reject parameter sets the counter or the synchronizer cannot honour.
    if (HOLD_CYCLES < 1 || STEP_CYCLES < 1 ||
        HOLD_CYCLES > (1 << CNT_W) - 1 || STEP_CYCLES > (1 << CNT_W) - 1 ||
        LOCK_SYNC_STAGES < 2) begin : g_bad_params
        $fatal(1, "amber128_reset_seq: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        WAIT_LOCK  = 3'd0,
        HOLD       = 3'd1,
        REL_PERIPH = 3'd2,
        REL_MEM    = 3'd3,
        RUN        = 3'd4
    } state_t;

    localparam logic [1:0] CAUSE_POR  = 2'b00;
    localparam logic [1:0] CAUSE_LOCK = 2'b01;
    localparam logic [1:0] CAUSE_SW   = 2'b10;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);

    state_t                      state;
    logic [CNT_W-1:0]            cnt;
    logic [LOCK_SYNC_STAGES-1:0] lock_sync;
    logic                        lock_s;
    logic                        rst_periph_n;
    logic                        rst_mem_n;
    logic                        rst_core_n;
    logic                        busy;
    logic                        sw_ack;
    logic [1:0]                  cause;

    // Bring the asynchronous PLL lock into the clk_i domain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_sync <= '0;
        end else begin
            lock_sync <= {lock_sync[LOCK_SYNC_STAGES-2:0], bus.pll_locked_i};
        end
    end

    assign lock_s = lock_sync[LOCK_SYNC_STAGES-1];

    // Sequencer: every output is a flop, so domain resets never glitch.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= WAIT_LOCK;
            cnt          <= '0;
            rst_periph_n <= 1'b0;
            rst_mem_n    <= 1'b0;
            rst_core_n   <= 1'b0;
            busy         <= 1'b1;
            sw_ack       <= 1'b0;
            cause        <= CAUSE_POR;
        end else begin
            sw_ack <= 1'b0;
            if (state != WAIT_LOCK && !lock_s) begin
                // Lock loss outranks everything, including a pending software request.
                state        <= WAIT_LOCK;
                cnt          <= '0;
                rst_periph_n <= 1'b0;
                rst_mem_n    <= 1'b0;
                rst_core_n   <= 1'b0;
                busy         <= 1'b1;
                cause        <= CAUSE_LOCK;
            end else begin
                case (state)
                    WAIT_LOCK: begin
                        cnt <= '0;
                        if (lock_s) state <= HOLD;
                    end
                    HOLD: begin
                        if (cnt == HOLD_LAST) begin
                            state        <= REL_PERIPH;
                            cnt          <= '0;
                            rst_periph_n <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    REL_PERIPH: begin
                        if (cnt == STEP_LAST) begin
                            state     <= REL_MEM;
                            cnt       <= '0;
                            rst_mem_n <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    REL_MEM: begin
                        if (cnt == STEP_LAST) begin
                            state      <= RUN;
                            cnt        <= '0;
                            rst_core_n <= 1'b1;
                            busy       <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    RUN: begin
                        // PLL is still good, so skip WAIT_LOCK and restart at HOLD.
                        if (bus.sw_rst_req_i) begin
                            state        <= HOLD;
                            cnt          <= '0;
                            rst_periph_n <= 1'b0;
                            rst_mem_n    <= 1'b0;
                            rst_core_n   <= 1'b0;
                            busy         <= 1'b1;
                            sw_ack       <= 1'b1;
                            cause        <= CAUSE_SW;
                        end
                    end
                    default: begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.rst_periph_no = rst_periph_n;
    assign bus.rst_mem_no    = rst_mem_n;
    assign bus.rst_core_no   = rst_core_n;
    assign bus.busy_o        = busy;
    assign bus.sw_ack_o      = sw_ack;
    assign bus.cause_o       = cause;

endmodule

// File: tb/tb_amber128_reset_seq.sv
// Bench for the reset sequencer. The stimulus process pushes every expected
// output change (edge number plus output vector) into a queue; the monitor
// watches the outputs and pops one entry each time they change.
module tb_amber128_reset_seq;

    // Output vector: {periph, mem, core, busy, ack, cause[1:0]}
    localparam logic [6:0] RST_VEC = 7'b000_1_0_00;

    typedef struct {
        string      name;
        int         edge_no;
        logic [6:0] vec;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_ni;
    int   edge_n = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    amber128_reset_seq_if bus();

    amber128_reset_seq dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    // Count rising edges so expectations can name an absolute edge.
    always @(posedge clk_i) edge_n <= edge_n + 1;

    function automatic logic [6:0] out_vec();
        return {bus.rst_periph_no, bus.rst_mem_no, bus.rst_core_no,
                bus.busy_o, bus.sw_ack_o, bus.cause_o};
    endfunction

    task automatic push(input string name, input int e, input logic [6:0] v);
        exp_t x;
        x.name = name;
        x.edge_no = e;
        x.vec = v;
        exp_q.push_back(x);
    endtask

    // Standard release sequence for lock seen before edge k.
    task automatic push_release(input string tag, input int k, input logic [1:0] c);
        push({tag, "_periph"}, k + 18, {3'b100, 1'b1, 1'b0, c});
        push({tag, "_mem"},    k + 26, {3'b110, 1'b1, 1'b0, c});
        push({tag, "_core"},   k + 34, {3'b111, 1'b0, 1'b0, c});
    endtask

    task automatic check_vec(input string name, input logic [6:0] got, input logic [6:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, got, want);
        end
    endtask

    task automatic wait_edge(input int e);
        while (edge_n < e) @(negedge clk_i);
    endtask

    // Monitor: any output change must match the next queued expectation.
    initial begin
        logic [6:0] prev;
        logic [6:0] cur;
        exp_t       x;
        prev = RST_VEC;
        forever begin
            @(negedge clk_i);
            cur = out_vec();
            if (cur !== prev) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change: outputs %b at edge %0d, none expected", cur, edge_n);
                end else begin
                    x = exp_q.pop_front();
                    if (cur !== x.vec || edge_n != x.edge_no) begin
                        n_fail++;
                        $display("FAIL %s: got %b at edge %0d, expected %b at edge %0d",
                                 x.name, cur, edge_n, x.vec, x.edge_no);
                    end
                end
                prev = cur;
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int s0;
        int j;

        rst_ni           = 1'b0;
        bus.pll_locked_i = 1'b1;
        bus.sw_rst_req_i = 1'b0;

        // POR with lock present throughout.
        repeat (5) @(negedge clk_i);
        check_vec("reset_state", out_vec(), RST_VEC);
        k = edge_n + 1;
        rst_ni = 1'b1;
        push_release("por", k, 2'b00);
        wait_edge(k + 40);

        // Lock loss in RUN, then 100 cycles without lock, then relock.
        j = edge_n + 1;
        bus.pll_locked_i = 1'b0;
        push("lock_loss", j + 2, 7'b000_1_0_01);
        wait_edge(j + 102);
        check_vec("late_lock_held", out_vec(), 7'b000_1_0_01);
        k = edge_n + 1;
        bus.pll_locked_i = 1'b1;
        push_release("relock", k, 2'b01);
        wait_edge(k + 40);

        // One-cycle software request in RUN; a second request during REL_MEM is ignored.
        s0 = edge_n + 1;
        bus.sw_rst_req_i = 1'b1;
        push("sw_accept",   s0,      7'b000_1_1_10);
        push("sw_ack_drop", s0 + 1,  7'b000_1_0_10);
        push("sw_periph",   s0 + 16, 7'b100_1_0_10);
        push("sw_mem",      s0 + 24, 7'b110_1_0_10);
        push("sw_core",     s0 + 32, 7'b111_0_0_10);
        @(negedge clk_i);
        bus.sw_rst_req_i = 1'b0;
        wait_edge(s0 + 26);
        bus.sw_rst_req_i = 1'b1;
        @(negedge clk_i);
        bus.sw_rst_req_i = 1'b0;
        wait_edge(s0 + 40);

        // Lock loss and software request seen in the same RUN cycle: lock loss wins.
        j = edge_n + 1;
        bus.pll_locked_i = 1'b0;
        push("prio_lock", j + 2, 7'b000_1_0_01);
        wait_edge(j + 1);
        bus.sw_rst_req_i = 1'b1;
        wait_edge(j + 2);
        bus.sw_rst_req_i = 1'b0;
        wait_edge(j + 6);
        k = edge_n + 1;
        bus.pll_locked_i = 1'b1;
        push_release("prio_relock", k, 2'b01);
        wait_edge(k + 40);

        // Software reset into REL_PERIPH, then asynchronous rst_ni mid-sequence.
        s0 = edge_n + 1;
        bus.sw_rst_req_i = 1'b1;
        push("sw2_accept",   s0,      7'b000_1_1_10);
        push("sw2_ack_drop", s0 + 1,  7'b000_1_0_10);
        push("sw2_periph",   s0 + 16, 7'b100_1_0_10);
        @(negedge clk_i);
        bus.sw_rst_req_i = 1'b0;
        wait_edge(s0 + 18);
        @(posedge clk_i);
        #3;
        push("async_rst", edge_n, RST_VEC);
        rst_ni = 1'b0;
        #1;
        check_vec("async_rst_immediate", out_vec(), RST_VEC);
        repeat (3) @(negedge clk_i);
        k = edge_n + 1;
        rst_ni = 1'b1;
        push_release("after_async", k, 2'b00);
        wait_edge(k + 40);

        // Everything expected must have been observed.
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: %0d expected changes never seen, next is %s",
                     exp_q.size(), exp_q[0].name);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/amber128_reset_seq.md
Name: amber128_reset_seq

Overview:
- Staged reset sequencer. It sits directly downstream of the platform reset synchronizer, whose synchronized output drives rst_ni.
- Combines the synchronized reset, PLL lock and a software reset request.
- Releases three reset domains in a fixed order: peripherals, then memory, then core.
- Programmable hold and step delays; reports the cause of the last reset for boot firmware.

Parameters:
- HOLD_CYCLES, 16: cycles all domains stay in reset after lock is seen, before the peripheral release.
- STEP_CYCLES, 8: cycles between successive domain releases.
- CNT_W, 8: width of the internal delay counter.
- LOCK_SYNC_STAGES, 2: flops in the pll_locked_i synchronizer; must be >= 2.

Ports:
- clk_i  in  1: system clock.
- rst_ni  in  1: reset, asynchronous, active-low; clock clk_i.
- pll_locked_i  in  1: PLL lock, asynchronous to clk_i; synchronized internally.
- sw_rst_req_i  in  1: software reset request, synchronous to clk_i, level-sensitive.
- rst_periph_no  out  1: peripheral domain reset, active-low, registered.
- rst_mem_no  out  1: memory domain reset, active-low, registered.
- rst_core_no  out  1: core domain reset, active-low, registered.
- busy_o  out  1: 1 while any domain is still held in reset.
- sw_ack_o  out  1: one-cycle pulse when a software reset is accepted.
- cause_o  out  2: last reset cause. 00 = POR/rst_ni, 01 = PLL lock loss, 10 = software, 11 = unused.

Behaviour:
- Elaboration-time fatal if any of these hold: HOLD_CYCLES < 1, STEP_CYCLES < 1, HOLD_CYCLES or STEP_CYCLES > 2^CNT_W - 1, LOCK_SYNC_STAGES < 2.
- rst_ni low, asynchronously:
  - all rst_*_no = 0, busy_o = 1, sw_ack_o = 0, cause_o = 00.
  - counter = 0, lock synchronizer = 0, state = WAIT_LOCK.
- Reset outputs assert asynchronously only via rst_ni. All other assertion and all release happen on the clk_i rising edge. Outputs are glitch-free flops, never decoded combinationally.
- lock_s is pll_locked_i delayed through LOCK_SYNC_STAGES flops.
- States and transitions:
  - WAIT_LOCK: all domains in reset, counter held at 0. lock_s = 1 -> HOLD.
  - HOLD: counter increments each edge. At the edge where counter == HOLD_CYCLES-1 -> REL_PERIPH; rst_periph_no <= 1 on that edge; counter <= 0.
  - REL_PERIPH: counter increments. At counter == STEP_CYCLES-1 -> REL_MEM; rst_mem_no <= 1; counter <= 0.
  - REL_MEM: counter increments. At counter == STEP_CYCLES-1 -> RUN; rst_core_no <= 1; busy_o <= 0.
  - RUN: all domains released, busy_o = 0.
- Release latency with default parameters, taking pll_locked_i rising before edge k:
  - lock_s = 1 after edge k+1; FSM enters HOLD at edge k+2.
  - rst_periph_no rises at edge k+2+HOLD_CYCLES (k+18).
  - rst_mem_no rises at edge k+26; rst_core_no and busy_o fall at edge k+34.
- Lock loss: lock_s = 0 in any state other than WAIT_LOCK. At the next edge:
  - all rst_*_no <= 0, busy_o <= 1, cause_o <= 01, counter <= 0.
  - state <= WAIT_LOCK.
- Software reset: sw_rst_req_i = 1 in RUN with lock_s = 1. At the next edge:
  - all rst_*_no <= 0, busy_o <= 1, cause_o <= 10, sw_ack_o <= 1 for exactly one cycle.
  - counter <= 0, state <= HOLD (WAIT_LOCK is skipped).
- sw_rst_req_i is ignored outside RUN: no ack, no cause change.
- If the request is still high on returning to RUN, it retriggers, with one ack per trigger.
- Simultaneous lock loss and software request: lock loss wins, cause_o = 01, no ack.
- Lock glitch mid-sequence: the sequence restarts from WAIT_LOCK, and every already-released domain is re-asserted.
- cause_o holds its value until the next reset event; it is not cleared in RUN.
- Counter never wraps. It is cleared on every state change and is compared for equality only.

Test Plan:
- POR: rst_ni low 5 cycles, pll_locked_i = 1 throughout, rst_ni released before edge 0 -> rst_periph_no rises at edge 18, rst_mem_no at 26, rst_core_no at 34. busy_o falls at 34; cause_o = 00.
- Late lock: rst_ni high, pll_locked_i low for 100 cycles -> all resets held low and busy_o = 1. Raise pll_locked_i before edge k -> releases at k+18, k+26, k+34.
- Lock loss in RUN: drop pll_locked_i -> all three resets low within LOCK_SYNC_STAGES+1 edges; cause_o = 01. Relock -> full sequence repeats.
- Software reset: sw_rst_req_i = 1 for one cycle in RUN -> sw_ack_o pulses once, resets low next edge, cause_o = 10. Periph release 16 edges later, core 32 edges later.
- Ignored request and priority: sw_rst_req_i = 1 during REL_MEM -> no ack, sequence unaffected. Request and lock loss in the same RUN cycle -> cause_o = 01, sw_ack_o = 0.
- Async reset mid-sequence: rst_ni low during REL_PERIPH -> rst_periph_no = 0 immediately without a clock edge; cause_o = 00; state WAIT_LOCK.
